// File: rtl/mc_pkg.sv
// Shared command codes and state encoding for the memory-controller responder.
// The command codes are also used by the core control FSM that drives it.
package mc_pkg;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_STORE = 3'b100;
    localparam logic [2:0] CMD_TRANS = 3'b010;
    localparam logic [2:0] CMD_PROC  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_READ  = 2'd2,
        ST_ACK   = 2'd3
    } mc_state_e;

endpackage

// File: rtl/mc_ram.sv
// Single-port synchronous RAM, registered read (read-before-write), no reset.
module mc_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write on enable; read data appears one cycle after the address.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl_responder.sv
// Memory-controller responder: stores an input burst into local RAM and moves
// fixed-size blocks from RAM into the processing register on command edges.
module mem_ctrl_responder
    import mc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int BLK_WORDS = 4
) (
    input  logic                        mc_clk,
    input  logic                        mc_reset_n,
    input  logic [2:0]                  ctrl_data_contition,
    input  logic [DATA_W-1:0]           mc_data_in,
    input  logic                        mc_data_in_valid,
    input  logic [ADDR_W:0]             mc_data_in_size,
    output logic                        mc_done,
    output logic                        mc_data_done,
    output logic [ADDR_W:0]             mc_data_length,
    output logic [BLK_WORDS*DATA_W-1:0] mc_reg_data,
    output logic                        mc_reg_valid,
    output logic                        mc_busy
);

    localparam int              CNT_W   = $clog2(BLK_WORDS + 1);
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] BLK_L   = (ADDR_W + 1)'(BLK_WORDS);

    mc_state_e                       state_q;
    logic [2:0]                      prev_q;
    logic [ADDR_W:0]                 len_q, wr_ptr_q, rd_ptr_q, length_q;
    logic [CNT_W-1:0]                cnt_q;
    logic                            pend_vld_q;
    logic [BLK_WORDS-1:0][DATA_W-1:0] reg_q;
    logic                            done_q, data_done_q, reg_valid_q;

    logic                            cmd_edge, start_store, start_trans, abort;
    logic [ADDR_W:0]                 size_clamped, slot_ptr, blk_sum, next_rd_d;
    logic                            slot_vld, wr_en;
    logic [ADDR_W-1:0]               ram_addr;
    logic [DATA_W-1:0]               ram_rdata;

    // Command decode: only a fresh store/transfer code starts anything.
    always_comb begin
        cmd_edge     = (ctrl_data_contition != prev_q);
        start_store  = cmd_edge && (ctrl_data_contition == CMD_STORE);
        start_trans  = cmd_edge && (ctrl_data_contition == CMD_TRANS);
        abort        = (ctrl_data_contition == CMD_IDLE);
        size_clamped = (mc_data_in_size > MAX_LEN) ? MAX_LEN : mc_data_in_size;
    end

    // Datapath: write gating, per-slot read address and end-of-block pointer.
    // rd_ptr_q is held during READ; slot c reads rd_ptr_q + c and is zeroed if
    // it lies past the stored length, so the pointer advance is just a clamp.
    always_comb begin
        wr_en     = (state_q == ST_STORE) && !abort && mc_data_in_valid &&
                    (wr_ptr_q < len_q);
        slot_ptr  = rd_ptr_q + (ADDR_W + 1)'(cnt_q);
        slot_vld  = (slot_ptr < length_q);
        ram_addr  = (state_q == ST_STORE) ? wr_ptr_q[ADDR_W-1:0]
                                          : slot_ptr[ADDR_W-1:0];
        blk_sum   = rd_ptr_q + BLK_L;
        next_rd_d = rd_ptr_q;
        if (rd_ptr_q < length_q)
            next_rd_d = (blk_sum > length_q) ? length_q : blk_sum;
    end

    mc_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (mc_clk),
        .we_i    (wr_en),
        .addr_i  (ram_addr),
        .wdata_i (mc_data_in),
        .rdata_o (ram_rdata)
    );

    // Control FSM with registered outputs; mc_done is high only in ACK.
    always_ff @(posedge mc_clk or negedge mc_reset_n) begin
        if (!mc_reset_n) begin
            state_q     <= ST_IDLE;
            prev_q      <= CMD_IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            length_q    <= '0;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            reg_q       <= '0;
            done_q      <= 1'b0;
            data_done_q <= 1'b0;
            reg_valid_q <= 1'b0;
        end else begin
            prev_q <= ctrl_data_contition;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_store) begin
                        state_q     <= ST_STORE;
                        len_q       <= size_clamped;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                        data_done_q <= 1'b0;
                        reg_valid_q <= 1'b0;
                    end else if (start_trans) begin
                        state_q     <= ST_READ;
                        cnt_q       <= '0;
                        pend_vld_q  <= 1'b0;
                        reg_valid_q <= 1'b0;
                    end
                end
                ST_STORE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (wr_ptr_q == len_q) begin
                            state_q     <= ST_ACK;
                            done_q      <= 1'b1;
                            length_q    <= len_q;
                            data_done_q <= (len_q == '0);
                        end
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        pend_vld_q <= slot_vld;
                        // RAM data for slot cnt_q-1 arrives this cycle
                        for (int s = 0; s < BLK_WORDS; s++)
                            if (cnt_q == CNT_W'(s + 1))
                                reg_q[s] <= pend_vld_q ? ram_rdata : '0;
                        if (cnt_q == CNT_W'(BLK_WORDS)) begin
                            state_q     <= ST_ACK;
                            done_q      <= 1'b1;
                            reg_valid_q <= 1'b1;
                            rd_ptr_q    <= next_rd_d;
                            data_done_q <= (next_rd_d >= length_q);
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_ACK: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mc_done        = done_q;
    assign mc_data_done   = data_done_q;
    assign mc_data_length = length_q;
    assign mc_reg_data    = reg_q;
    assign mc_reg_valid   = reg_valid_q;
    assign mc_busy        = (state_q == ST_STORE) || (state_q == ST_READ);

endmodule

// File: tb/tb_mem_ctrl_responder.sv
// Bench for mem_ctrl_responder: directed sequence plus randomized bursts,
// checked against a word-array model of the stored burst and read pointer.
module tb_mem_ctrl_responder;
    import mc_pkg::*;

    logic        mc_clk = 1'b0;
    logic        mc_reset_n;
    logic [2:0]  ctrl;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [6:0]  size_in;
    logic        mc_done, mc_data_done, mc_reg_valid, mc_busy;
    logic [6:0]  mc_data_length;
    logic [31:0] mc_reg_data;

    int vectors = 0;
    int errs    = 0;

    // reference model: stored words, stored length, read pointer, flags
    logic [7:0] m_mem [64];
    int         m_len = 0;
    int         m_rd  = 0;
    bit         m_dd  = 0;

    always #5 mc_clk = ~mc_clk;

    mem_ctrl_responder #(.DATA_W(8), .ADDR_W(6), .BLK_WORDS(4)) dut (
        .mc_clk              (mc_clk),
        .mc_reset_n          (mc_reset_n),
        .ctrl_data_contition (ctrl),
        .mc_data_in          (data_in),
        .mc_data_in_valid    (valid_in),
        .mc_data_in_size     (size_in),
        .mc_done             (mc_done),
        .mc_data_done        (mc_data_done),
        .mc_data_length      (mc_data_length),
        .mc_reg_data         (mc_reg_data),
        .mc_reg_valid        (mc_reg_valid),
        .mc_busy             (mc_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Store burst; words are base+i, or random when rnd is set. gap is the
    // percentage of cycles with valid low (0 = valid held high).
    task automatic do_store(input int size, input bit rnd, input logic [7:0] base, input int gap);
        int len, idx, cyc, last, expc;
        bit seen;
        logic [7:0] w;
        len = (size > 64) ? 64 : size;
        ctrl = CMD_IDLE; valid_in = 1'b0;
        @(negedge mc_clk);
        ctrl = CMD_STORE; size_in = 7'(size);
        cyc = 0; idx = 0; last = 0; seen = 0;
        m_rd = 0; m_dd = 0;
        while (cyc < 400 && !seen) begin
            @(negedge mc_clk);
            cyc++;
            if (mc_done) seen = 1;
            else begin
                if (cyc == 1) check("store_busy", mc_busy, 1);
                valid_in = (gap == 0) || ($urandom_range(99) >= gap);
                w = rnd ? 8'($urandom) : base + 8'(idx);
                data_in = w;
                if (valid_in && idx < len) begin
                    m_mem[idx] = w;
                    idx++;
                    last = cyc;
                end
            end
        end
        expc = (len == 0) ? 2 : last + 2;
        m_len = len;
        m_dd  = (len == 0);
        check("store_done_seen", seen, 1);
        check("store_latency", cyc, expc);
        check("store_length", mc_data_length, len);
        check("store_data_done", mc_data_done, m_dd);
        check("store_reg_valid", mc_reg_valid, 0);
        valid_in = 1'b0;
        @(negedge mc_clk);
        check("store_done_width", mc_done, 0);
        check("store_idle_busy", mc_busy, 0);
    endtask

    // Transfer one block (code goes through 001 so a fresh 010 edge is seen).
    task automatic do_read();
        int cyc;
        bit seen;
        logic [31:0] exp;
        ctrl = CMD_PROC;
        @(negedge mc_clk);
        ctrl = CMD_TRANS;
        cyc = 0; seen = 0;
        while (cyc < 20 && !seen) begin
            @(negedge mc_clk);
            cyc++;
            if (mc_done) seen = 1;
        end
        exp = '0;
        for (int s = 0; s < 4; s++)
            if (m_rd + s < m_len) exp[8*s +: 8] = m_mem[m_rd + s];
        if (m_rd < m_len) m_rd = (m_rd + 4 > m_len) ? m_len : m_rd + 4;
        m_dd = (m_rd >= m_len);
        check("read_done_seen", seen, 1);
        check("read_latency", cyc, 6);
        check("read_reg_data", mc_reg_data, exp);
        check("read_reg_valid", mc_reg_valid, 1);
        check("read_data_done", mc_data_done, m_dd);
        @(negedge mc_clk);
        check("read_done_width", mc_done, 0);
    endtask

    initial begin
        bit any_done, any_busy;
        int nrd;
        mc_reset_n = 1'b0; ctrl = CMD_IDLE; data_in = '0; valid_in = 1'b0; size_in = '0;
        repeat (3) @(negedge mc_clk);
        check("rst_done", mc_done, 0);
        check("rst_data_done", mc_data_done, 0);
        check("rst_length", mc_data_length, 0);
        check("rst_reg_data", mc_reg_data, 0);
        check("rst_reg_valid", mc_reg_valid, 0);
        check("rst_busy", mc_busy, 0);
        mc_reset_n = 1'b1;
        @(negedge mc_clk);

        // 6-word burst 0x11..0x16, then two blocks
        do_store(6, 0, 8'h11, 0);
        do_read();
        check("blk0_const", mc_reg_data, 32'h14131211);
        do_read();
        check("blk1_const", mc_reg_data, 32'h00001615);
        check("blk1_done_const", mc_data_done, 1);

        // zero-length burst
        do_store(0, 0, 8'h00, 0);
        do_read();

        // abort a store of 8 after 3 words; data_done was 1 before
        ctrl = CMD_IDLE; @(negedge mc_clk);
        ctrl = CMD_STORE; size_in = 7'd8;
        m_rd = 0; m_dd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge mc_clk);
            valid_in = 1'b1; data_in = 8'hE0 + 8'(i);
            m_mem[i] = data_in;
        end
        @(negedge mc_clk);
        ctrl = CMD_IDLE; valid_in = 1'b0;
        any_done = 0;
        repeat (8) begin
            @(negedge mc_clk);
            any_done |= mc_done;
        end
        check("abort_no_done", any_done, 0);
        check("abort_busy", mc_busy, 0);
        check("abort_data_done", mc_data_done, 0);
        check("abort_length", mc_data_length, m_len);
        do_store(5, 0, 8'hA0, 0);
        do_read();
        do_read();

        // oversize burst: clamped to 64, then drain it
        do_store(70, 1, 8'h00, 0);
        for (int i = 0; i < 17; i++) do_read();

        // randomized bursts with gaps, drained plus one extra block
        for (int it = 0; it < 4; it++) begin
            do_store($urandom_range(70), 1, 8'h00, 30);
            nrd = (m_len + 3) / 4 + 1;
            for (int i = 0; i < nrd; i++) do_read();
        end

        // reset in the middle of a READ
        do_store(6, 0, 8'h31, 0);
        do_read();
        ctrl = CMD_PROC; @(negedge mc_clk);
        ctrl = CMD_TRANS;
        repeat (2) @(negedge mc_clk);
        #2 mc_reset_n = 1'b0;
        #1;
        check("arst_busy", mc_busy, 0);
        check("arst_reg_data", mc_reg_data, 0);
        check("arst_length", mc_data_length, 0);
        check("arst_data_done", mc_data_done, 0);
        check("arst_reg_valid", mc_reg_valid, 0);
        check("arst_done", mc_done, 0);
        m_len = 0; m_rd = 0; m_dd = 0;
        @(negedge mc_clk);
        ctrl = 3'b011;
        mc_reset_n = 1'b1;
        any_done = 0; any_busy = 0;
        repeat (8) begin
            @(negedge mc_clk);
            any_done |= mc_done;
            any_busy |= mc_busy;
        end
        check("code011_no_done", any_done, 0);
        check("code011_no_busy", any_busy, 0);
        do_store(3, 1, 8'h00, 0);
        do_read();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
